tdc_readout_sched: RTL and testbench

TDC_READOUT_SCHED -- requirements
Module: tdc_readout_sched

---
 rtl/tdc_readout_sched_if.sv | 30 +++
 rtl/tdc_readout_sched.sv | 136 +++++++++++++
 tb/tb_tdc_readout_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tdc_readout_sched_if.sv
// Readout bus between the TDC frame buffers, the SPI word engine and the scheduler.
// The scheduler uses the slave side; the buffers and SPI engine use the master side.
interface tdc_readout_sched_if #(
  parameter int TO_W = 16
);
  logic            raw_req;
  logic [2:0]      raw_num;
  logic            peak_req;
  logic [2:0]      peak_num;
  logic            SPI_Odstart;
  logic [TO_W-1:0] timeout_max;
  logic            grant_raw;
  logic            grant_peak;
  logic [2:0]      rd_idx;
  logic [2:0]      word_tag;
  logic            raw_ack;
  logic            peak_ack;
  logic            INT_out;
  logic            abort;

  modport master (
    output raw_req, raw_num, peak_req, peak_num, SPI_Odstart, timeout_max,
    input  grant_raw, grant_peak, rd_idx, word_tag, raw_ack, peak_ack, INT_out, abort
  );

  modport slave (
    input  raw_req, raw_num, peak_req, peak_num, SPI_Odstart, timeout_max,
    output grant_raw, grant_peak, rd_idx, word_tag, raw_ack, peak_ack, INT_out, abort
  );
endinterface

// File: rtl/tdc_readout_sched.sv
// Readout scheduler: arbitrates raw and peak frames onto the SPI word mux,
// steps through the frame words and drops stalled frames via a watchdog.
module tdc_readout_sched #(
  parameter int TO_W = 16,
  parameter int MAXW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  tdc_readout_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE, RETIRE} state_t;

  localparam logic [2:0] MAXW_L = 3'(MAXW);

  state_t          state, state_d;
  logic            grant_raw_q, grant_raw_d;
  logic            grant_peak_q, grant_peak_d;
  logic [2:0]      rd_idx_q, rd_idx_d;
  logic [2:0]      len_q, len_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            raw_ack_q, raw_ack_d;
  logic            peak_ack_q, peak_ack_d;
  logic            abort_q, abort_d;
  logic            last_peak_q, last_peak_d;
  logic            int_q;
  logic [2:0]      tag_q;
  logic            pick_peak;
  logic            retire;

  // Zero-length frames still carry one word; oversize frames are clipped.
  function automatic logic [2:0] frame_len(input logic [2:0] num);
    if (num == 3'd0)
      return 3'd1;
    else if (num > MAXW_L)
      return MAXW_L;
    else
      return num;
  endfunction

  always_comb begin
    state_d      = state;
    grant_raw_d  = grant_raw_q;
    grant_peak_d = grant_peak_q;
    rd_idx_d     = rd_idx_q;
    len_d        = len_q;
    wd_d         = wd_q;
    raw_ack_d    = 1'b0;
    peak_ack_d   = 1'b0;
    abort_d      = 1'b0;
    last_peak_d  = last_peak_q;
    pick_peak    = 1'b0;
    retire       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.raw_req || bus.peak_req) begin
          // On a tie the source not served last wins.
          pick_peak    = bus.peak_req && (!bus.raw_req || !last_peak_q);
          state_d      = SERVE;
          grant_peak_d = pick_peak;
          grant_raw_d  = !pick_peak;
          last_peak_d  = pick_peak;
          rd_idx_d     = 3'd0;
          wd_d         = '0;
          len_d        = frame_len(pick_peak ? bus.peak_num : bus.raw_num);
        end
      end
      SERVE: begin
        if (bus.SPI_Odstart) begin
          if (rd_idx_q < len_q - 3'd1) begin
            rd_idx_d = rd_idx_q + 3'd1;
            wd_d     = '0;
          end else begin
            retire = 1'b1;
          end
        end else if (bus.timeout_max != '0 && wd_q == bus.timeout_max - TO_W'(1)) begin
          retire  = 1'b1;
          abort_d = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + TO_W'(1);
        end
        if (retire) begin
          state_d      = RETIRE;
          grant_raw_d  = 1'b0;
          grant_peak_d = 1'b0;
          rd_idx_d     = 3'd0;
          wd_d         = '0;
          raw_ack_d    = grant_raw_q;
          peak_ack_d   = grant_peak_q;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_raw_q  <= 1'b0;
      grant_peak_q <= 1'b0;
      rd_idx_q     <= 3'd0;
      len_q        <= 3'd1;
      wd_q         <= '0;
      raw_ack_q    <= 1'b0;
      peak_ack_q   <= 1'b0;
      abort_q      <= 1'b0;
      last_peak_q  <= 1'b0;
      int_q        <= 1'b0;
      tag_q        <= 3'd0;
    end else begin
      state        <= state_d;
      grant_raw_q  <= grant_raw_d;
      grant_peak_q <= grant_peak_d;
      rd_idx_q     <= rd_idx_d;
      len_q        <= len_d;
      wd_q         <= wd_d;
      raw_ack_q    <= raw_ack_d;
      peak_ack_q   <= peak_ack_d;
      abort_q      <= abort_d;
      last_peak_q  <= last_peak_d;
      int_q        <= grant_raw_d | grant_peak_d;
      tag_q        <= (grant_raw_d | grant_peak_d) ? rd_idx_d + 3'd1 : 3'd0;
    end
  end

  assign bus.grant_raw  = grant_raw_q;
  assign bus.grant_peak = grant_peak_q;
  assign bus.rd_idx     = rd_idx_q;
  assign bus.word_tag   = tag_q;
  assign bus.raw_ack    = raw_ack_q;
  assign bus.peak_ack   = peak_ack_q;
  assign bus.INT_out    = int_q;
  assign bus.abort      = abort_q;

endmodule

// File: tb/tb_tdc_readout_sched.sv
// Directed bench for tdc_readout_sched: frame sequencing, arbitration,
// length clipping, watchdog and reset behaviour.
module tb_tdc_readout_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  tdc_readout_sched_if #(.TO_W(16)) bus ();

  tdc_readout_sched #(.TO_W(16), .MAXW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view: {grant_raw, grant_peak, INT_out, rd_idx, word_tag, raw_ack, peak_ack, abort}
  task automatic chk(input string tag, input logic gr, input logic gp,
                     input logic [2:0] idx, input logic ra, input logic pa, input logic ab);
    logic [11:0] obs;
    logic [11:0] exp;
    logic [2:0]  etag;
    etag = (gr | gp) ? idx + 3'd1 : 3'd0;
    exp  = {gr, gp, gr | gp, idx, etag, ra, pa, ab};
    obs  = {bus.grant_raw, bus.grant_peak, bus.INT_out, bus.rd_idx, bus.word_tag,
            bus.raw_ack, bus.peak_ack, bus.abort};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.raw_req     = 1'b0;
    bus.raw_num     = 3'd0;
    bus.peak_req    = 1'b0;
    bus.peak_num    = 3'd0;
    bus.SPI_Odstart = 1'b0;
    bus.timeout_max = 16'd0;
    #3 chk("reset_async", 0, 0, 3'd0, 0, 0, 0);
    tick(); tick();
    chk("reset_held", 0, 0, 3'd0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_release", 0, 0, 3'd0, 0, 0, 0);

    // Single raw frame of three words
    bus.raw_req = 1'b1; bus.raw_num = 3'd3;
    tick(); chk("raw_grant", 1, 0, 3'd0, 0, 0, 0);
    bus.raw_req = 1'b0; bus.raw_num = 3'd0; bus.SPI_Odstart = 1'b1;
    tick(); chk("raw_word2", 1, 0, 3'd1, 0, 0, 0);
    bus.SPI_Odstart = 1'b0;
    tick(); chk("raw_hold", 1, 0, 3'd1, 0, 0, 0);
    bus.SPI_Odstart = 1'b1;
    tick(); chk("raw_word3", 1, 0, 3'd2, 0, 0, 0);
    tick(); chk("raw_retire_ack", 0, 0, 3'd0, 1, 0, 0);
    tick(); chk("retire_spi_ignored", 0, 0, 3'd0, 0, 0, 0);
    tick(); chk("idle_spi_ignored", 0, 0, 3'd0, 0, 0, 0);
    bus.SPI_Odstart = 1'b0;

    // Tie: peak first, then raw
    bus.raw_req = 1'b1; bus.peak_req = 1'b1; bus.raw_num = 3'd2; bus.peak_num = 3'd2;
    tick(); chk("tie_peak_first", 0, 1, 3'd0, 0, 0, 0);
    bus.peak_req = 1'b0; bus.SPI_Odstart = 1'b1;
    tick(); chk("tie_peak_word2", 0, 1, 3'd1, 0, 0, 0);
    tick(); chk("tie_peak_retire", 0, 0, 3'd0, 0, 1, 0);
    bus.SPI_Odstart = 1'b0;
    tick(); chk("tie_gap_idle", 0, 0, 3'd0, 0, 0, 0);
    tick(); chk("tie_raw_second", 1, 0, 3'd0, 0, 0, 0);
    bus.SPI_Odstart = 1'b1;
    tick(); chk("tie_raw_word2", 1, 0, 3'd1, 0, 0, 0);
    tick(); chk("tie_raw_retire", 0, 0, 3'd0, 1, 0, 0);
    bus.raw_req = 1'b0; bus.SPI_Odstart = 1'b0;
    tick(); chk("tie_done_idle", 0, 0, 3'd0, 0, 0, 0);

    // Length clipping: num 0 -> 1 word, num 7 -> 5 words
    bus.peak_req = 1'b1; bus.peak_num = 3'd0;
    tick(); chk("len1_grant", 0, 1, 3'd0, 0, 0, 0);
    bus.peak_num = 3'd7; bus.SPI_Odstart = 1'b1;
    tick(); chk("len1_retire", 0, 0, 3'd0, 0, 1, 0);
    bus.SPI_Odstart = 1'b0;
    tick(); chk("len5_idle", 0, 0, 3'd0, 0, 0, 0);
    tick(); chk("len5_grant", 0, 1, 3'd0, 0, 0, 0);
    bus.peak_req = 1'b0; bus.peak_num = 3'd1; bus.SPI_Odstart = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("len5_word", 0, 1, 3'(i), 0, 0, 0);
    end
    tick(); chk("len5_retire", 0, 0, 3'd0, 0, 1, 0);
    bus.SPI_Odstart = 1'b0;
    tick();

    // Watchdog expiry after 8 idle SERVE cycles
    bus.timeout_max = 16'd8; bus.raw_req = 1'b1; bus.raw_num = 3'd2;
    tick(); chk("wd_grant", 1, 0, 3'd0, 0, 0, 0);
    bus.raw_req = 1'b0;
    repeat (7) tick();
    chk("wd_before_expiry", 1, 0, 3'd0, 0, 0, 0);
    tick(); chk("wd_abort", 0, 0, 3'd0, 1, 0, 1);
    tick(); chk("wd_abort_pulse_end", 0, 0, 3'd0, 0, 0, 0);

    // SPI pulse in the expiry cycle wins, then watchdog rearms
    bus.peak_req = 1'b1; bus.peak_num = 3'd2;
    tick(); chk("wd2_grant", 0, 1, 3'd0, 0, 0, 0);
    bus.peak_req = 1'b0;
    repeat (7) tick();
    bus.SPI_Odstart = 1'b1;
    tick(); chk("wd_spi_wins", 0, 1, 3'd1, 0, 0, 0);
    bus.SPI_Odstart = 1'b0;
    repeat (7) tick();
    chk("wd_rearmed", 0, 1, 3'd1, 0, 0, 0);
    tick(); chk("wd_abort2", 0, 0, 3'd0, 0, 1, 1);
    tick();

    // Watchdog disabled
    bus.timeout_max = 16'd0; bus.raw_req = 1'b1; bus.raw_num = 3'd2;
    tick(); chk("wd_off_grant", 1, 0, 3'd0, 0, 0, 0);
    bus.raw_req = 1'b0;
    repeat (20) tick();
    chk("wd_disabled", 1, 0, 3'd0, 0, 0, 0);
    bus.SPI_Odstart = 1'b1;
    tick(); tick();
    chk("wd_off_retire", 0, 0, 3'd0, 1, 0, 0);
    bus.SPI_Odstart = 1'b0;
    tick();

    // Reset in word 2 of a 4-word peak frame
    bus.peak_req = 1'b1; bus.peak_num = 3'd4;
    tick(); chk("rst_frame_grant", 0, 1, 3'd0, 0, 0, 0);
    bus.peak_req = 1'b0; bus.SPI_Odstart = 1'b1;
    tick(); chk("rst_frame_word2", 0, 1, 3'd1, 0, 0, 0);
    bus.SPI_Odstart = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_midframe_async", 0, 0, 3'd0, 0, 0, 0);
    tick(); chk("reset_no_ack", 0, 0, 3'd0, 0, 0, 0);
    rst_n = 1'b1;
    bus.raw_req = 1'b1; bus.peak_req = 1'b1; bus.raw_num = 3'd1; bus.peak_num = 3'd1;
    tick(); chk("post_reset_tie_peak", 0, 1, 3'd0, 0, 0, 0);
    bus.peak_req = 1'b0; bus.SPI_Odstart = 1'b1;
    tick(); chk("post_reset_peak_retire", 0, 0, 3'd0, 0, 1, 0);
    bus.SPI_Odstart = 1'b0;
    tick(); chk("post_reset_idle", 0, 0, 3'd0, 0, 0, 0);
    tick(); chk("post_reset_raw_grant", 1, 0, 3'd0, 0, 0, 0);
    bus.SPI_Odstart = 1'b1;
    tick(); chk("post_reset_raw_retire", 0, 0, 3'd0, 1, 0, 0);
    bus.raw_req = 1'b0; bus.SPI_Odstart = 1'b0;
    tick(); chk("final_idle", 0, 0, 3'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
